bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
Sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit output nibble drives one decoder instance.
Start/done handshake lets counters and ALU results feed the display without a wide combinational converter.

---
 rtl/bin2bcd_seq_pkg.sv | 23 ++
 rtl/bin2bcd_seq_if.sv | 21 ++
 rtl/bin2bcd_seq_dabble_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 99 +++++++++
 tb/tb_bin2bcd_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Provides the FSM state encoding, the BCD digit type and a constant
// power-of-ten helper used for the elaboration-time width check.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake bundle between a requester and bin2bcd_seq.
//   start : request a conversion (requester -> converter)
//   bin   : unsigned binary value, W bits (requester -> converter)
//   busy  : conversion in progress (converter -> requester)
//   done  : one-cycle pulse, bcd holds a new result (converter -> requester)
//   bcd   : D packed BCD digits, digit 0 = units (converter -> requester)
interface bin2bcd_seq_if #(
  parameter int W = 8,
  parameter int D = 3
) ();

  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);

endinterface

// File: rtl/bin2bcd_seq_dabble_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   in_i  : BCD digit before correction
//   out_o : corrected digit (4-bit add, no carry out)
module dabble_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t in_i,
  output bcd_digit_t out_o
);

  assign out_o = (in_i >= 4'd5) ? bcd_digit_t'(in_i + 4'd3) : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock
// (shift-and-add-3). Feeds per-digit 7-segment decoders via bus.bcd.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bin2bcd_seq_if (start/bin in, busy/done/bcd out)
//
// state | meaning
// IDLE  | waiting for start, bcd holds last result
// SHIFT | one correct+shift step per cycle, cnt bits remaining
// DONE  | done pulse, new result visible on bcd
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W  = BCD_DIGIT_W * D;
  localparam int WORK_W = BCD_W + W;
  localparam int CNT_W  = $clog2(W + 1);

  if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_bad_params
    $error("bin2bcd_seq: D=%0d digits cannot represent all W=%0d bit values", D, W);
  end

  conv_state_t       state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              done_q, done_d;

  logic [BCD_W-1:0]  adj;
  logic [WORK_W-1:0] work_pre;
  logic [WORK_W-1:0] work_shl;

  for (genvar g = 0; g < D; g++) begin : g_adj
    dabble_adj u_adj (
      .in_i  (work_q[W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .out_o (adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Correct every digit first, then shift the whole register by one.
  assign work_pre = {adj, work_q[W-1:0]};
  assign work_shl = {work_pre[WORK_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = {{BCD_W{1'b0}}, bus.bin};
          cnt_d   = CNT_W'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_shl;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = work_shl[WORK_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake cases plus all
// 256 inputs in random order, compared with a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic rst;

  bin2bcd_seq_if #(.W(W), .D(D)) bus ();

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit mon_en = 1'b0;
  logic [11:0] held_bcd = '0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Continuous checks: digits always decimal, bcd only changes on done or reset.
  always @(negedge clk) begin
    if (mon_en) begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < D; i++) if (bus.bcd[4*i +: 4] > 4'd9) ok = 1'b0;
      chk_eq("nibble_le9", 32'(ok), 32'd1);
      if (rst) begin
        chk_eq("bcd_in_reset", 32'(bus.bcd), 32'h0);
        held_bcd = '0;
      end else if (bus.done) begin
        held_bcd = bus.bcd;
      end else begin
        chk_eq("bcd_held", 32'(bus.bcd), 32'(held_bcd));
      end
    end
  end

  // One full conversion starting from IDLE at a negedge; ends at a negedge in IDLE.
  task automatic run_conv(input int v);
    int lat;
    int busy_cnt;
    logic [11:0] res;
    bus.start = 1'b1;
    bus.bin   = 8'(v);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = 8'($urandom);
    lat = -1;
    busy_cnt = 0;
    res = '0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n;
        res = bus.bcd;
        break;
      end
    end
    chk_eq("latency", 32'(lat), 32'(W));
    chk_eq("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    chk_eq($sformatf("bcd_%0d", v), 32'(res), 32'(ref_bcd(v)));
    @(negedge clk);
    chk_eq("busy_after", 32'(bus.busy), 32'd0);
    chk_eq("done_after", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int vals[256];
    int done_cnt;
    int pos[$];
    logic [11:0] got[$];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_done", 32'(bus.done), 32'd0);
    chk_eq("rst_bcd", 32'(bus.bcd), 32'h0);
    rst = 1'b0;
    held_bcd = '0;
    mon_en = 1'b1;
    @(negedge clk);

    run_conv(0);
    run_conv(255);

    // start while busy is ignored
    bus.start = 1'b1;
    bus.bin = 8'd99;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin = 8'd7;
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 2) bus.start = 1'b1;
      if (n == 3) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        chk_eq("busy_start_lat", 32'(n), 32'(W));
        chk_eq("busy_start_bcd", 32'(bus.bcd), 32'h099);
      end
    end
    chk_eq("busy_start_dones", 32'(done_cnt), 32'd1);
    chk_eq("busy_start_idle", 32'(bus.busy), 32'd0);

    // start held high: back-to-back conversions
    bus.start = 1'b1;
    bus.bin = 8'd128;
    @(posedge clk);
    #1;
    bus.bin = 8'd42;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        pos.push_back(n);
        got.push_back(bus.bcd);
        if (pos.size() == 2) break;
      end
    end
    bus.start = 1'b0;
    chk_eq("b2b_count", 32'(pos.size()), 32'd2);
    if (pos.size() == 2) begin
      chk_eq("b2b_spacing", 32'(pos[1] - pos[0]), 32'(W + 2));
      chk_eq("b2b_first", 32'(got[0]), 32'h128);
      chk_eq("b2b_second", 32'(got[1]), 32'h042);
    end
    repeat (3) @(negedge clk);

    // async reset mid-conversion
    bus.start = 1'b1;
    bus.bin = 8'd200;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_busy", 32'(bus.busy), 32'd0);
    chk_eq("arst_done", 32'(bus.done), 32'd0);
    chk_eq("arst_bcd", 32'(bus.bcd), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_conv(17);

    // all inputs, random order, random idle gaps
    for (int i = 0; i < 256; i++) vals[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = vals[i];
      vals[i] = vals[j];
      vals[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_conv(vals[i]);
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
